// File: rtl/dtw_query_dispatch.sv
// Round-robin query dispatcher: copies qid + SQG_SIZE samples from the FWFT input FIFO into one idle, loaded core, then pulses its rs.
// Writes land 1 cycle after each pop; either FIFO side stalls the copy. `DTW_DISPATCH_STATS_EN adds query_count/stall_count.
module dtw_query_dispatch #(
   parameter int NCORES     = 4,
   parameter int SQG_SIZE   = 250,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  in_empty,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_rden,
   input  logic [NCORES-1:0]     core_load_done,
   input  logic [NCORES-1:0]     core_busy,
   input  logic [NCORES-1:0]     core_full,
   output logic [NCORES-1:0]     core_wren,
   output logic [DATA_WIDTH-1:0] core_data,
   output logic [NCORES-1:0]     core_rs,
   output logic [3:0]            sel_core,
   output logic                  dispatch_busy
`ifdef DTW_DISPATCH_STATS_EN
   ,
   output logic [31:0]           query_count,
   output logic [31:0]           stall_count
`endif
);
   localparam int CW = $clog2(SQG_SIZE + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(SQG_SIZE);

   typedef enum logic [1:0] {IDLE, SELECT, FORWARD, START} state_t;

   state_t                state, state_n;
   logic [NCORES-1:0]     reserved, reserved_n;
   logic [NCORES-1:0]     avail, sel_mask, cand_mask;
   logic [3:0]            ptr, ptr_n, sel_n, pick;
   logic                  found, sel_full;
   int                    cand;
   logic [CW-1:0]         word_cnt, cnt_n;
   logic [NCORES-1:0]     wren_n, rs_n;
   logic [DATA_WIDTH-1:0] data_n;

   // reserved masks a just-started core until its busy flag catches up
   assign avail         = core_load_done & ~core_busy & ~reserved;
   assign sel_mask      = NCORES'(1) << sel_core;
   assign sel_full      = |(core_full & sel_mask);
   assign in_rden       = (state == FORWARD) && !in_empty && !sel_full;
   assign dispatch_busy = (state != IDLE);

   always_comb begin
      found     = 1'b0;
      pick      = ptr;
      cand      = 0;
      cand_mask = '0;
      for (int k = 1; k <= NCORES; k++) begin
         cand      = (int'(ptr) + k) % NCORES;
         cand_mask = NCORES'(1) << cand;
         if (!found && |(avail & cand_mask)) begin
            found = 1'b1;
            pick  = 4'(cand);
         end
      end
   end

   always_comb begin
      state_n    = state;
      reserved_n = reserved & ~core_busy;
      ptr_n      = ptr;
      sel_n      = sel_core;
      cnt_n      = word_cnt;
      wren_n     = '0;
      data_n     = core_data;
      rs_n       = '0;
      case (state)
         IDLE: begin
            if (enable && !in_empty && |avail)
               state_n = SELECT;
         end
         SELECT: begin
            if (found) begin
               sel_n   = pick;
               ptr_n   = pick;
               cnt_n   = '0;
               state_n = FORWARD;
            end else begin
               state_n = IDLE;
            end
         end
         FORWARD: begin
            if (in_rden) begin
               wren_n = sel_mask;
               data_n = in_data;
               cnt_n  = word_cnt + 1'b1;
               if (word_cnt == LAST_CNT)
                  state_n = START;
            end
         end
         START: begin
            // rs is registered, so it lands one cycle after the final write
            rs_n       = sel_mask;
            reserved_n = reserved_n | sel_mask;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         reserved  <= '0;
         ptr       <= 4'(NCORES - 1);
         sel_core  <= '0;
         word_cnt  <= '0;
         core_wren <= '0;
         core_data <= '0;
         core_rs   <= '0;
      end else begin
         state     <= state_n;
         reserved  <= reserved_n;
         ptr       <= ptr_n;
         sel_core  <= sel_n;
         word_cnt  <= cnt_n;
         core_wren <= wren_n;
         core_data <= data_n;
         core_rs   <= rs_n;
      end
   end

`ifdef DTW_DISPATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         query_count <= '0;
         stall_count <= '0;
      end else begin
         if (state == START && query_count != '1)
            query_count <= query_count + 1'b1;
         if (state == FORWARD && !in_rden && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dtw_query_dispatch.sv
// Bench for dtw_query_dispatch: input FIFO and core models, dispatch scoreboard, table vectors, random round-robin check.
module tb_dtw_query_dispatch;
   localparam int NC   = 4;
   localparam int SQ   = 250;
   localparam int DW   = 32;
   localparam int QW   = SQ + 1;
   localparam int HOLD = 1000000;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          in_empty;
   logic [DW-1:0] in_data;
   logic          in_rden;
   logic [NC-1:0] core_load_done;
   logic [NC-1:0] core_busy;
   logic [NC-1:0] core_full;
   logic [NC-1:0] core_wren;
   logic [DW-1:0] core_data;
   logic [NC-1:0] core_rs;
   logic [3:0]    sel_core;
   logic          dispatch_busy;
`ifdef DTW_DISPATCH_STATS_EN
   logic [31:0]   query_count;
   logic [31:0]   stall_count;
`endif

   always #5 clk = ~clk;

   dtw_query_dispatch #(.NCORES(NC), .SQG_SIZE(SQ), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_empty(in_empty), .in_data(in_data),
      .in_rden(in_rden), .core_load_done(core_load_done), .core_busy(core_busy),
      .core_full(core_full), .core_wren(core_wren), .core_data(core_data),
      .core_rs(core_rs), .sel_core(sel_core), .dispatch_busy(dispatch_busy)
`ifdef DTW_DISPATCH_STATS_EN
      , .query_count(query_count), .stall_count(stall_count)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int tick_no = 0;

   logic [DW-1:0] in_q[$];
   logic [DW-1:0] exp_words[$];
   logic [DW-1:0] col[$];
   int            col_core, col_first, last_wr_tick;
   bit            col_bad, pop_pend;
   int            disp_core[$];
   int            disp_first[$];
   int            busy_left[NC];
   int            busy_len[NC];
   int            busy_fall[NC];
   bit            busy_start[NC];
   bit            rand_full, rand_starve, rand_en, toggle_full1;
   int            starve_left;

   typedef struct packed {
      logic [NC-1:0]       mask;
      logic [NC-1:0][19:0] bl;
      logic [3:0]          nq;
      logic [4:0][3:0]     exp_c;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (tick %0d)", nm, act, exp, tick_no);
      end
   endtask

   function automatic int low_idx(input logic [NC-1:0] v);
      int r = -1;
      for (int i = NC - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic monitor();
      int c;
      bit ok;
      if (rst) begin
         col.delete();
         col_bad = 1'b0;
         return;
      end
      if (core_wren != '0) begin
         if (!$onehot(core_wren)) col_bad = 1'b1;
         if (col.size() == 0) begin
            col_core  = low_idx(core_wren);
            col_first = tick_no;
         end else if (low_idx(core_wren) != col_core) begin
            col_bad = 1'b1;
         end
         col.push_back(core_data);
         last_wr_tick = tick_no;
      end
      if (core_rs != '0) begin
         c  = low_idx(core_rs);
         ok = $onehot(core_rs) && !col_bad && col.size() == QW && c == col_core
              && exp_words.size() >= QW;
         if (ok) for (int i = 0; i < QW; i++) if (col[i] !== exp_words[i]) ok = 1'b0;
         check("dispatch_data", ok, 1);
         check("rs_after_last_write", tick_no - last_wr_tick, 1);
         check("sel_core_at_rs", sel_core, c);
         disp_core.push_back(c);
         disp_first.push_back(col_first);
         for (int i = 0; i < QW && exp_words.size() > 0; i++) void'(exp_words.pop_front());
         col.delete();
         col_bad = 1'b0;
      end
   endtask

   task automatic env();
      if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
      pop_pend = 1'b0;
      for (int i = 0; i < NC; i++) begin
         if (busy_start[i]) begin
            busy_start[i] = 1'b0;
            busy_left[i]  = busy_len[i];
         end else if (busy_left[i] > 0) begin
            busy_left[i]--;
            if (busy_left[i] == 0) busy_fall[i] = tick_no;
         end
         if (core_rs[i]) busy_start[i] = 1'b1;
         core_busy[i] = (busy_left[i] > 0);
      end
      in_empty = (in_q.size() == 0) || (starve_left > 0) || (rand_starve && $urandom_range(0, 4) == 0);
      if (starve_left > 0) starve_left--;
      in_data = (in_q.size() > 0) ? in_q[0] : '0;
      if (rand_full) core_full = NC'($urandom) & NC'($urandom);
      else if (toggle_full1) core_full = {2'b00, 1'(((tick_no / 3) % 2) == 1), 1'b0};
      else core_full = '0;
      if (rand_en) enable = ($urandom_range(0, 3) != 0);
   endtask

   task automatic tick();
      @(negedge clk);
      tick_no++;
      monitor();
      env();
      #1;
      pop_pend = in_rden;
   endtask

   task automatic reset_all();
      rst = 1'b1;
      enable = 1'b1;
      in_q.delete();
      exp_words.delete();
      pop_pend = 1'b0;
      rand_full = 1'b0; rand_starve = 1'b0; rand_en = 1'b0; toggle_full1 = 1'b0;
      starve_left = 0;
      for (int i = 0; i < NC; i++) begin
         busy_left[i] = 0; busy_start[i] = 1'b0; busy_len[i] = 20; busy_fall[i] = 0;
      end
      core_busy = '0;
      tick();
      tick();
      rst = 1'b0;
      disp_core.delete();
      disp_first.delete();
   endtask

   task automatic send_query(input logic [DW-1:0] qid);
      logic [DW-1:0] w;
      in_q.push_back(qid);
      exp_words.push_back(qid);
      for (int i = 0; i < SQ; i++) begin
         w = $urandom;
         in_q.push_back(w);
         exp_words.push_back(w);
      end
   endtask

   task automatic wait_disp(input int n, input int budget);
      int t = 0;
      while (disp_core.size() < n && t < budget) begin tick(); t++; end
      if (disp_core.size() < n) check("dispatch_timeout", disp_core.size(), n);
   endtask

   task automatic wait_col(input int n, input int budget);
      int t = 0;
      while (col.size() < n && t < budget) begin tick(); t++; end
      if (col.size() < n) check("write_timeout", col.size(), n);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev, c, got;
      rst = 1'b1; enable = 1'b0; in_empty = 1'b1; in_data = '0;
      core_load_done = '0; core_busy = '0; core_full = '0;

      tbl[0] = '{mask: 4'b1111, bl: {4{20'd20}}, nq: 4'd1, exp_c: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
      tbl[1] = '{mask: 4'b1111, bl: {20'd1000000, 20'd400, 20'd1000000, 20'd1000000}, nq: 4'd5,
                 exp_c: {4'd2, 4'd3, 4'd2, 4'd1, 4'd0}};
      tbl[2] = '{mask: 4'b0100, bl: {4{20'd20}}, nq: 4'd3, exp_c: {4'd0, 4'd0, 4'd2, 4'd2, 4'd2}};
      tbl[3] = '{mask: 4'b1010, bl: {4{20'd20}}, nq: 4'd3, exp_c: {4'd0, 4'd0, 4'd1, 4'd3, 4'd1}};
      tbl[4] = '{mask: 4'b1001, bl: {4{20'd20}}, nq: 4'd3, exp_c: {4'd0, 4'd0, 4'd0, 4'd3, 4'd0}};

      reset_all();
      check("reset_in_rden", in_rden, 0);
      check("reset_core_wren", core_wren, 0);
      check("reset_core_data", core_data, 0);
      check("reset_core_rs", core_rs, 0);
      check("reset_sel_core", sel_core, 0);
      check("reset_dispatch_busy", dispatch_busy, 0);

      for (int r = 0; r < 5; r++) begin
         reset_all();
         core_load_done = tbl[r].mask;
         for (int i = 0; i < NC; i++) busy_len[i] = int'(tbl[r].bl[i]);
         for (int q = 0; q < int'(tbl[r].nq); q++)
            send_query((r == 0) ? 32'h11 : DW'(32'h100 * r + q));
         wait_disp(int'(tbl[r].nq), int'(tbl[r].nq) * 1500);
         for (int k = 0; k < int'(tbl[r].nq); k++) begin
            got = (k < disp_core.size()) ? disp_core[k] : -1;
            check($sformatf("table%0d_core%0d", r, k), got, int'(tbl[r].exp_c[k]));
         end
         if (r == 1 && disp_first.size() == 5)
            check("q5_waits_for_core2", disp_first[4] > busy_fall[2], 1);
      end

      // core_full[1] toggling while query 2 streams into core 1
      reset_all();
      core_load_done = 4'b1111;
      toggle_full1 = 1'b1;
      send_query(32'h21);
      send_query(32'h22);
      wait_disp(2, 3000);
      got = (disp_core.size() > 1) ? disp_core[1] : -1;
      check("full_toggle_core", got, 1);

      // enable drop mid-query finishes the query, then holds in IDLE
      reset_all();
      core_load_done = 4'b1111;
      send_query(32'h31);
      send_query(32'h32);
      wait_col(50, 500);
      enable = 1'b0;
      wait_disp(1, 1500);
      repeat (300) tick();
      check("enable_low_holds", disp_core.size(), 1);
      check("enable_low_idle", dispatch_busy, 0);
      enable = 1'b1;
      wait_disp(2, 1500);
      got = (disp_core.size() > 1) ? disp_core[1] : -1;
      check("enable_resume_core", got, 1);

      // reset in the middle of a transfer
      reset_all();
      core_load_done = 4'b1111;
      send_query(32'h41);
      send_query(32'h42);
      wait_col(100, 500);
      rst = 1'b1;
      tick();
      check("midrst_core_wren", core_wren, 0);
      check("midrst_in_rden", in_rden, 0);
      check("midrst_dispatch_busy", dispatch_busy, 0);
      check("midrst_sel_core", sel_core, 0);
      in_q.delete();
      exp_words.delete();
      rst = 1'b0;
      disp_core.delete();
      disp_first.delete();
      send_query(32'h77);
      wait_disp(1, 1500);
      got = (disp_core.size() > 0) ? disp_core[0] : -1;
      check("midrst_next_core", got, 0);

`ifdef DTW_DISPATCH_STATS_EN
      reset_all();
      core_load_done = 4'b1111;
      for (int q = 0; q < 3; q++) send_query(DW'(32'h50 + q));
      wait_col(50, 500);
      starve_left = 10;
      wait_disp(3, 4000);
      tick();
      tick();
      check("query_count", query_count, 3);
      check("stall_count", stall_count, 10);
`endif

      // randomized traffic against round-robin-over-loaded-cores reference
      for (int rnd = 0; rnd < 3; rnd++) begin
         reset_all();
         core_load_done = 4'($urandom_range(1, 15));
         for (int i = 0; i < NC; i++) busy_len[i] = $urandom_range(1, 200);
         rand_full = 1'b1; rand_starve = 1'b1; rand_en = 1'b1;
         for (int q = 0; q < 6; q++) send_query($urandom);
         wait_disp(6, 6 * 2500);
         prev = NC - 1;
         for (int k = 0; k < 6; k++) begin
            c = prev;
            for (int s = 1; s <= NC; s++)
               if (core_load_done[(prev + s) % NC]) begin c = (prev + s) % NC; break; end
            got = (k < disp_core.size()) ? disp_core[k] : -1;
            check($sformatf("rand%0d_core%0d", rnd, k), got, c);
            prev = c;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dtw_query_dispatch.md
Name: dtw_query_dispatch

Overview:
- Shares one incoming query stream between NCORES dtw_core instances.
- Each query is 1 qid word followed by SQG_SIZE sample words. The block picks an idle, reference-loaded core in round-robin order, copies the whole query into that core's source FIFO, then pulses that core's rs.
- Sits between the AXIS-to-FIFO input bridge and the per-core source FIFOs, in front of the dtw_core array.

Parameters:
- NCORES, 4, number of dtw_core instances served (1..16).
- SQG_SIZE, 250, sample words per query, excluding the qid word.
- DATA_WIDTH, 32, FIFO word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  dispatch allowed; sampled only in IDLE.
- in_empty  in  1  input FIFO empty; FWFT, so in_data is valid whenever this is low.
- in_data  in  DATA_WIDTH  input FIFO head word.
- in_rden  out  1  input FIFO pop, combinational.
- core_load_done  in  NCORES  per-core load_done.
- core_busy  in  NCORES  per-core busy.
- core_full  in  NCORES  per-core source FIFO almost-full (at least 1 word of slack).
- core_wren  out  NCORES  per-core source FIFO write enable, registered, one-hot or zero.
- core_data  out  DATA_WIDTH  write data shared by all cores, registered.
- core_rs  out  NCORES  per-core start pulse, one cycle wide, one-hot or zero.
- sel_core  out  4  index of the core currently or last selected.
- dispatch_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: in_rden=0, core_wren=0, core_data=0, core_rs=0, sel_core=0, dispatch_busy=0, reserved=0, word_cnt=0, state=IDLE, round-robin pointer=NCORES-1.
- Core availability:
  - avail[i] = core_load_done[i] & ~core_busy[i] & ~reserved[i].
  - reserved[i] is set in the cycle core_rs[i] pulses.
  - reserved[i] clears on the first cycle core_busy[i] is observed high. This covers the core's one-cycle lag between rs and busy.
- IDLE:
  - Go to SELECT when enable=1, in_empty=0 and any avail bit is set.
  - Otherwise stay in IDLE.
- SELECT (1 cycle):
  - Choose the first avail core searching from pointer+1 upward, modulo NCORES.
  - Latch its index into sel_core, update pointer to that index, clear word_cnt, go to FORWARD.
  - If avail has dropped to zero in the meantime, return to IDLE.
- FORWARD:
  - in_rden = ~in_empty & ~core_full[sel_core].
  - Each pop:
    - Next cycle: core_wren[sel_core]=1 and core_data = the popped word.
    - word_cnt increments.
  - When the pop with word_cnt == SQG_SIZE completes (SQG_SIZE+1 words total), go to START.
  - A stall on either side holds word_cnt and holds all state.
- START (1 cycle):
  - core_rs[sel_core]=1 and reserved[sel_core] is set.
  - The last core_wren was issued in the previous cycle, so rs is never asserted before the final word is written.
  - Next state is IDLE.
- Dispatch rate: back-to-back queries cost 3 overhead cycles (IDLE, SELECT, START) plus SQG_SIZE+1 transfer cycles at minimum.
- Width rule: word_cnt is ceil(log2(SQG_SIZE+1)) bits.
- Boundary conditions:
  - enable dropping mid-query does not abort; the current query completes.
  - core_busy or core_load_done of the selected core changing during FORWARD is ignored.
  - in_empty and core_full simultaneously: no pop.
  - NCORES=1: pointer is always 0.
  - Reset mid-FORWARD: everything returns to reset values. The partially written core FIFO is the caller's to clear; dtw_core clears its own FIFO in IDLE.
  - A core with load_done=0 is never selected.

Optional Feature:
- Macro DTW_DISPATCH_STATS_EN.
- When defined, the following ports are added:
  - query_count out 32: counts START cycles; saturates at 0xFFFFFFFF; cleared by rst.
  - stall_count out 32: counts FORWARD cycles with in_rden=0; saturates at 0xFFFFFFFF; cleared by rst.
- When undefined, neither port nor its counter exists, and all other behaviour is identical.

Test Plan:
- NCORES=4, all loaded and idle, 1 query (qid=0x11, 250 samples) preloaded. Required response:
  - core_wren[0] pulses 251 times with data 0x11 then the samples.
  - core_rs[0] pulses once, 1 cycle after the last write.
  - sel_core=0.
- 4 queries back-to-back with cores held busy after rs. Required response:
  - Dispatched to cores 0,1,2,3 in order.
  - A 5th query waits in IDLE until core_busy[2] falls, then goes to core 2.
- core_full[1] toggled every 3 cycles during FORWARD:
  - No word lost or duplicated.
  - Exactly 251 writes; core_rs is asserted only after word 251.
- core_load_done=4'b0100 → every query goes to core 2 only, never to cores 0, 1 or 3.
- rst asserted at word_cnt=100:
  - The next cycle shows core_wren=0, in_rden=0, dispatch_busy=0.
  - The next query starts with its qid word.
- With DTW_DISPATCH_STATS_EN, 3 queries and input starved for 10 FORWARD cycles → query_count=3, stall_count=10.
